// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB master: FSM state encoding,
// per-quarter SIO_C/SIO_D levels for START/STOP/GAP and the byte selector.
package sccb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BYTE  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4,
        ST_RESP  = 3'd5
    } sccb_state_e;

    localparam logic [6:0] OV7670_ID = 7'h21;

    // Bit q of each constant is the line level during quarter q.
    localparam logic [3:0] START_C = 4'b0011;
    localparam logic [3:0] START_D = 4'b0001;
    localparam logic [3:0] STOP_C  = 4'b1110;
    localparam logic [3:0] STOP_D  = 4'b1100;
    localparam logic [3:0] GAP_C   = 4'b1111;
    localparam logic [3:0] GAP_D   = 4'b1111;
    localparam logic [3:0] BIT_C   = 4'b1100;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

    // Byte driven in a given phase/slot; the read phase only ever drives the ID byte.
    function automatic logic [7:0] select_byte(
        input logic [6:0] dev,
        input logic [7:0] reg_addr,
        input logic [7:0] wdata,
        input logic       phase,
        input logic [1:0] idx
    );
        logic [7:0] b;
        if (phase) begin
            b = {dev, 1'b1};
        end else begin
            case (idx)
                2'd0:    b = {dev, 1'b0};
                2'd1:    b = reg_addr;
                default: b = wdata;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/sccb_quarter_tick.sv
// Quarter-period prescaler: one-cycle qtick every CLK_DIV clocks, held at zero
// while clear is high so the first quarter after clear is full length.
module sccb_quarter_tick #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic reset_,
    input  logic clear,
    output logic qtick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign qtick = !clear && (cnt_q == CNT_MAX);

endmodule

// File: rtl/sccb_master.sv
// SCCB master for OV7670 register access: one 3-phase write or 2+2-phase read
// per command, read byte returned on the rsp_* port.
module sccb_master
    import sccb_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_read,
    input  logic [6:0] cmd_dev_addr,
    input  logic [7:0] cmd_reg_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       sioc,
    output logic       siod_o,
    output logic       siod_oe,
    input  logic       siod_i
);

    // Handshakes: a transfer happens on a clk edge where valid && ready are both
    // high; cmd_ready is high only in IDLE, and rsp_valid/rsp_data hold in RESP
    // until rsp_ready is seen.

    sccb_state_e state_q, state_d;
    logic [1:0]  quarter_q, quarter_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        phase_q, phase_d;
    logic        read_q, read_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        sioc_q, sioc_d;
    logic        siod_o_q, siod_o_d;
    logic        siod_oe_q, siod_oe_d;

    logic        qtick;
    logic        last_byte;
    logic        rx_byte_d;
    logic [7:0]  tx_byte;
    logic [2:0]  bit_sel;

    sccb_quarter_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_quarter_tick (
        .clk    (clk),
        .reset_ (reset_),
        .clear  (state_q == ST_IDLE),
        .qtick  (qtick)
    );

    // Reads end after the register byte in phase 0 and after the data byte in phase 1.
    assign last_byte = read_q ? (byte_idx_q == 2'd1) : (byte_idx_q == 2'd2);

    always_comb begin
        state_d    = state_q;
        quarter_d  = quarter_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        phase_d    = phase_q;
        read_d     = read_q;
        dev_d      = dev_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        shift_d    = shift_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d    = ST_START;
                    quarter_d  = 2'd0;
                    bit_cnt_d  = BITS_PER_BYTE;
                    byte_idx_d = 2'd0;
                    phase_d    = 1'b0;
                    read_d     = cmd_read;
                    dev_d      = cmd_dev_addr;
                    reg_addr_d = cmd_reg_addr;
                    wdata_d    = cmd_wdata;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (qtick) begin
                    quarter_d = quarter_q + 2'd1;
                    // SIO_D is sampled as the q2 quarter ends, mid-way through SIO_C high.
                    if ((state_q == ST_BYTE) && (quarter_q == 2'd2) && phase_q &&
                        (byte_idx_q == 2'd1) && (bit_cnt_q != 4'd0)) begin
                        shift_d = {shift_q[6:0], siod_i};
                    end
                    if (quarter_q == 2'd3) begin
                        case (state_q)
                            ST_START: state_d = ST_BYTE;
                            ST_BYTE: begin
                                if (bit_cnt_q != 4'd0) begin
                                    bit_cnt_d = bit_cnt_q - 4'd1;
                                end else if (last_byte) begin
                                    state_d = ST_STOP;
                                end else begin
                                    byte_idx_d = byte_idx_q + 2'd1;
                                    bit_cnt_d  = BITS_PER_BYTE;
                                end
                            end
                            ST_STOP: begin
                                if (!read_q) begin
                                    state_d = ST_IDLE;
                                end else if (!phase_q) begin
                                    state_d = ST_GAP;
                                end else begin
                                    state_d    = ST_RESP;
                                    rsp_data_d = shift_q;
                                end
                            end
                            ST_GAP: begin
                                state_d    = ST_START;
                                phase_d    = 1'b1;
                                byte_idx_d = 2'd0;
                                bit_cnt_d  = BITS_PER_BYTE;
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Bus levels are computed from the next state so the registered pins line up
    // with the state they belong to.
    assign tx_byte   = select_byte(dev_d, reg_addr_d, wdata_d, phase_d, byte_idx_d);
    assign bit_sel   = 3'(bit_cnt_d - 4'd1);
    assign rx_byte_d = phase_d && (byte_idx_d == 2'd1);

    always_comb begin
        sioc_d    = 1'b1;
        siod_o_d  = 1'b1;
        siod_oe_d = 1'b1;
        case (state_d)
            ST_START: begin
                sioc_d   = START_C[quarter_d];
                siod_o_d = START_D[quarter_d];
            end
            ST_STOP: begin
                sioc_d   = STOP_C[quarter_d];
                siod_o_d = STOP_D[quarter_d];
            end
            ST_GAP: begin
                sioc_d   = GAP_C[quarter_d];
                siod_o_d = GAP_D[quarter_d];
            end
            ST_BYTE: begin
                sioc_d = BIT_C[quarter_d];
                if (bit_cnt_d == 4'd0) begin
                    // Ninth bit: released after written bytes, driven high (NA) after the read byte.
                    siod_oe_d = rx_byte_d;
                end else if (rx_byte_d) begin
                    siod_oe_d = 1'b0;
                end else begin
                    siod_o_d = tx_byte[bit_sel];
                end
            end
            default: ;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= ST_IDLE;
            quarter_q   <= 2'd0;
            bit_cnt_q   <= 4'd0;
            byte_idx_q  <= 2'd0;
            phase_q     <= 1'b0;
            read_q      <= 1'b0;
            dev_q       <= 7'd0;
            reg_addr_q  <= 8'd0;
            wdata_q     <= 8'd0;
            shift_q     <= 8'd0;
            rsp_data_q  <= 8'd0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            sioc_q      <= 1'b1;
            siod_o_q    <= 1'b1;
            siod_oe_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            quarter_q   <= quarter_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            phase_q     <= phase_d;
            read_q      <= read_d;
            dev_q       <= dev_d;
            reg_addr_q  <= reg_addr_d;
            wdata_q     <= wdata_d;
            shift_q     <= shift_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            sioc_q      <= sioc_d;
            siod_o_q    <= siod_o_d;
            siod_oe_q   <= siod_oe_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign sioc      = sioc_q;
    assign siod_o    = siod_o_q;
    assign siod_oe   = siod_oe_q;

endmodule

// File: tb/tb_sccb_master.sv
// Self-checking bench for sccb_master: bus monitor/slave decodes SIO_C/SIO_D into
// tokens that are matched against an expected-token scoreboard.
module tb_sccb_master;
    import sccb_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int WR_CLKS = 116 * CLK_DIV;
    localparam int RD_CLKS = 164 * CLK_DIV;
    localparam int W       = 11;

    // Token layout: [10:9] kind (0 byte, 1 START, 2 STOP, 3 ninth bit), [8] drive flag, [7:0] data.
    localparam logic [W-1:0] TOK_START = 11'h200;
    localparam logic [W-1:0] TOK_STOP  = 11'h400;
    localparam logic [W-1:0] TOK_REL   = 11'h601;
    localparam logic [W-1:0] TOK_NA    = 11'h701;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_read = 1'b0;
    logic [6:0] cmd_dev_addr = 7'd0;
    logic [7:0] cmd_reg_addr = 8'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       busy;
    logic       sioc;
    logic       siod_o;
    logic       siod_oe;
    logic       siod_i;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int checks = 0;
    int failures = 0;

    logic       sioc_prev = 1'b1;
    logic       line_prev = 1'b1;
    logic       line_now;
    int         bitn = 0;
    int         byte_no = 0;
    logic       rd_mode = 1'b0;
    logic [7:0] sh = 8'd0;
    logic       any_oe = 1'b0;
    logic [7:0] slave_data = 8'd0;
    logic [7:0] slave_sh = 8'd0;
    logic       slave_oe = 1'b0;
    logic       slave_bit = 1'b1;

    sccb_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .reset_       (reset_),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_read     (cmd_read),
        .cmd_dev_addr (cmd_dev_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .sioc         (sioc),
        .siod_o       (siod_o),
        .siod_oe      (siod_oe),
        .siod_i       (siod_i)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus monitor + slave model ----------------
    assign siod_i = slave_oe ? slave_bit : 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            line_now = siod_oe ? siod_o : siod_i;
            if (sioc_prev === 1'b1 && sioc === 1'b1 && line_prev === 1'b1 && line_now === 1'b0) begin
                got_q.push_back(TOK_START);
                bitn = 0; byte_no = 0; rd_mode = 1'b0; slave_oe = 1'b0; slave_sh = slave_data;
            end else if (sioc_prev === 1'b1 && sioc === 1'b1 && line_prev === 1'b0 && line_now === 1'b1) begin
                got_q.push_back(TOK_STOP);
                bitn = 0; slave_oe = 1'b0;
            end else if (sioc_prev === 1'b0 && sioc === 1'b1) begin
                if (bitn < 8) begin
                    sh = {sh[6:0], line_now};
                    any_oe = (bitn == 0) ? siod_oe : (any_oe | siod_oe);
                end
                bitn++;
                if (bitn == 8) begin
                    got_q.push_back({2'b00, any_oe, sh});
                end else if (bitn == 9) begin
                    got_q.push_back({2'b11, siod_oe, 7'd0, line_now});
                    if (byte_no == 0) rd_mode = sh[0];
                    byte_no++;
                    bitn = 0;
                end
            end else if (sioc_prev === 1'b1 && sioc === 1'b0) begin
                slave_oe = rd_mode && (byte_no == 1) && (bitn < 8);
                if (slave_oe) begin
                    slave_bit = slave_sh[7];
                    slave_sh  = {slave_sh[6:0], 1'b0};
                end
            end
            sioc_prev = sioc;
            line_prev = line_now;
        end
    end

    // ---------------- expected-token model ----------------
    function automatic void exp_write(input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
        exp_q.push_back(TOK_START);
        exp_q.push_back({3'b001, dev, 1'b0}); exp_q.push_back(TOK_REL);
        exp_q.push_back({3'b001, ra});        exp_q.push_back(TOK_REL);
        exp_q.push_back({3'b001, wd});        exp_q.push_back(TOK_REL);
        exp_q.push_back(TOK_STOP);
    endfunction

    function automatic void exp_read(input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] rd);
        exp_q.push_back(TOK_START);
        exp_q.push_back({3'b001, dev, 1'b0}); exp_q.push_back(TOK_REL);
        exp_q.push_back({3'b001, ra});        exp_q.push_back(TOK_REL);
        exp_q.push_back(TOK_STOP);
        exp_q.push_back(TOK_START);
        exp_q.push_back({3'b001, dev, 1'b1}); exp_q.push_back(TOK_REL);
        exp_q.push_back({3'b000, rd});        exp_q.push_back(TOK_NA);
        exp_q.push_back(TOK_STOP);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic rd, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_wait_ready: cmd_ready=%b after %0d clks, expected 1", cmd_ready, n);
        end
        cmd_valid = 1'b1; cmd_read = rd; cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_wdata = wd;
        @(negedge clk);
        cmd_valid    = 1'b0;
        cmd_read     = 1'($urandom_range(0, 1));
        cmd_dev_addr = 7'($urandom_range(0, 127));
        cmd_reg_addr = 8'($urandom_range(0, 255));
        cmd_wdata    = 8'($urandom_range(0, 255));
    endtask

    task automatic count_ready_low(output int n);
        n = 0;
        while (cmd_ready === 1'b0 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_ = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sioc, siod_o, siod_oe, cmd_ready} !== 4'b1111) begin
            failures++;
            $display("FAIL reset_pins: sioc/siod_o/siod_oe/cmd_ready=%b expected 1111", {sioc, siod_o, siod_oe, cmd_ready});
        end
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_status: rsp_valid/busy=%b expected 00", {rsp_valid, busy});
        end
        checks++;
        if (rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rsp_data: got %h expected 00", rsp_data);
        end
        reset_ = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, sioc, siod_oe} !== 4'b1011) begin
            failures++;
            $display("FAIL reset_release: cmd_ready/busy/sioc/siod_oe=%b expected 1011", {cmd_ready, busy, sioc, siod_oe});
        end
        got_q.delete();
    endtask

    task automatic test_write();
        int n;
        logic [7:0] ra, wd;
        logic [W-1:0] e, g;
        for (int k = 0; k < 2; k++) begin
            ra = (k == 0) ? 8'h12 : 8'($urandom_range(0, 255));
            wd = (k == 0) ? 8'h80 : 8'($urandom_range(0, 255));
            exp_write(OV7670_ID, ra, wd);
            send_cmd(1'b0, OV7670_ID, ra, wd);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL write_busy: got %b expected 1", busy);
            end
            count_ready_low(n);
            checks++;
            if (n !== WR_CLKS) begin
                failures++;
                $display("FAIL write_ready_low: got %0d clks expected %0d", n, WR_CLKS);
            end
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                failures++;
                $display("FAIL write_tok_count: got %0d tokens expected %0d", got_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front();
                g = got_q.pop_front();
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL write_token: got %h expected %h", g, e);
                end
            end
            exp_q.delete(); got_q.delete();
        end
    endtask

    task automatic test_read();
        int n;
        logic [W-1:0] e, g;
        slave_data = 8'h76;
        exp_read(OV7670_ID, 8'h0A, 8'h76);
        send_cmd(1'b1, OV7670_ID, 8'h0A, 8'h00);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== RD_CLKS) begin
            failures++;
            $display("FAIL read_latency: got %0d clks expected %0d", n, RD_CLKS);
        end
        checks++;
        if (rsp_data !== 8'h76) begin
            failures++;
            $display("FAIL read_rsp_data: got %h expected 76", rsp_data);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL read_tok_count: got %0d tokens expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL read_token: got %h expected %h", g, e);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_rsp_backpressure();
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                cmd_valid = 1'b1; cmd_read = 1'b0; cmd_dev_addr = OV7670_ID;
                cmd_reg_addr = 8'h99; cmd_wdata = 8'h66;
            end
            if (i == 21) cmd_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 8'h76, 1'b0}) begin
                failures++;
                $display("FAIL hold_rsp: cycle %0d rsp_valid/rsp_data/cmd_ready=%b/%h/%b expected 1/76/0",
                         i, rsp_valid, rsp_data, cmd_ready);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL rsp_release: rsp_valid/cmd_ready/busy=%b expected 010", {rsp_valid, cmd_ready, busy});
        end
        repeat (40) @(negedge clk);
        checks++;
        if (got_q.size() !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_cmd: %0d bus tokens, busy=%b, expected 0 tokens and idle", got_q.size(), busy);
        end
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        int n;
        logic [W-1:0] e, g;
        send_cmd(1'b0, OV7670_ID, 8'h33, 8'h5A);
        repeat (208) @(negedge clk);
        reset_ = 1'b0;
        #1;
        checks++;
        if ({sioc, siod_o, siod_oe, cmd_ready, busy, rsp_valid} !== 6'b111100) begin
            failures++;
            $display("FAIL midreset_pins: sioc/siod_o/siod_oe/cmd_ready/busy/rsp_valid=%b expected 111100",
                     {sioc, siod_o, siod_oe, cmd_ready, busy, rsp_valid});
        end
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);
        exp_q.delete(); got_q.delete();
        exp_write(OV7670_ID, 8'h12, 8'h34);
        send_cmd(1'b0, OV7670_ID, 8'h12, 8'h34);
        count_ready_low(n);
        checks++;
        if (n !== WR_CLKS) begin
            failures++;
            $display("FAIL midreset_ready_low: got %0d clks expected %0d", n, WR_CLKS);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL midreset_tok_count: got %0d tokens expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL midreset_token: got %h expected %h", g, e);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_busy_hold();
        int n;
        logic [W-1:0] e, g;
        logic [7:0] junk;
        exp_write(OV7670_ID, 8'h55, 8'hC3);
        while (cmd_ready !== 1'b1) @(negedge clk);
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_dev_addr = OV7670_ID; cmd_reg_addr = 8'h55; cmd_wdata = 8'hC3;
        @(negedge clk);
        n = 0;
        while (cmd_ready === 1'b0 && n < 5000) begin
            junk = 8'($urandom_range(0, 255));
            cmd_wdata = (junk == 8'hC3) ? 8'h3C : junk;
            n++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (n !== WR_CLKS) begin
            failures++;
            $display("FAIL busy_ready_low: got %0d clks expected %0d", n, WR_CLKS);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL busy_tok_count: got %0d tokens expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL busy_token: got %h expected %h", g, e);
            end
        end
        exp_q.delete(); got_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        logic [W-1:0] e, g;
        exp_write(OV7670_ID, 8'h3A, 8'h11);
        exp_write(OV7670_ID, 8'h3B, 8'h22);
        send_cmd(1'b0, OV7670_ID, 8'h3A, 8'h11);
        count_ready_low(n1);
        send_cmd(1'b0, OV7670_ID, 8'h3B, 8'h22);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_gap: cmd_ready=%b one cycle after second accept, expected 0", cmd_ready);
        end
        count_ready_low(n2);
        checks++;
        if (n1 !== WR_CLKS || n2 !== WR_CLKS) begin
            failures++;
            $display("FAIL b2b_ready_low: got %0d/%0d clks expected %0d", n1, n2, WR_CLKS);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL b2b_tok_count: got %0d tokens expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL b2b_token: got %h expected %h", g, e);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_write();
        test_read();
        test_rsp_backpressure();
        test_reset_mid();
        test_busy_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sccb_master.md
# sccb_master

SCCB (I2C-compatible) bus master that serves the OV7670 camera driver's register-access commands. It accepts one register write or register read per valid/ready handshake and serialises it onto SIO_C/SIO_D using the OV7670 3-phase write and 2+2-phase read cycles. For reads it returns the register byte on a valid/ready response port. It sits between the camera driver (initiator) and the camera's SIO_C/SIO_D pins; the top level builds the SIO_D tristate from `siod_o`/`siod_oe`.

## Interface
- `CLK_DIV`, default 250: clk cycles per quarter SIO_C period (100 MHz → 100 kHz SIO_C). Legal range is ≥ 2.
- `clk` in 1: sole clock.
- `reset_` in 1: asynchronous, active-low reset. Deassertion must be synchronous to `clk`.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block idle; accepts the command on this edge.
- `cmd_read` in 1: 1 = register read, 0 = register write.
- `cmd_dev_addr` in 7: 7-bit device ID (OV7670 = 7'h21).
- `cmd_reg_addr` in 8: sub-address.
- `cmd_wdata` in 8: write data; ignored for reads.
- `rsp_valid` out 1: read data available.
- `rsp_ready` in 1: consumer accepts the read data.
- `rsp_data` out 8: read byte.
- `busy` out 1: transaction in progress, including a pending response.
- `sioc` out 1: SIO_C.
- `siod_o` out 1: SIO_D drive value.
- `siod_oe` out 1: SIO_D drive enable; 0 releases the line.
- `siod_i` in 1: SIO_D sampled value. The block does not synchronise it; the top level adds a 2-flop synchroniser.

## Operation
- A prescaler emits a 1-cycle `qtick` every `CLK_DIV` clks. Every bus step lasts exactly 4 quarters (q0–q3).
- The prescaler is held at 0 in IDLE so the first quarter of a transaction is full length.
- Quarter levels, given as C/D:
  - START: 1/1, 1/0, 0/0, 0/0.
  - BIT: q0 changes D with C=0; q1 C=0; q2, q3 C=1. `siod_i` is sampled at the end of q2.
  - STOP: 0/0, 1/0, 1/1, 1/1.
  - GAP: 1/1 for all 4 quarters.
- Bytes go out MSB first, 8 data bits plus a 9th "don't-care" bit.
  - During the 9th bit of a written byte: `siod_oe`=0. The ack value is not checked.
  - During the 8 data bits of a read byte: `siod_oe`=0.
  - During the 9th bit of a read byte: the master drives NA, `siod_o`=1.
- Write sequence: START, {dev,0}, reg, wdata, STOP.
- Read sequence: START, {dev,0}, reg, STOP, GAP, START, {dev,1}, read byte, NA, STOP.
- FSM states: IDLE → START → BYTE → STOP → (GAP → START → BYTE → STOP for the read phase) → RESP (reads only) → IDLE.
  - A 2-bit byte index selects the shifted byte.
  - A 4-bit bit counter runs 8 down to 0.
  - A phase flag marks the read phase.
- The command is registered on accept; inputs are don't-care afterwards.
- `cmd_valid` while `cmd_ready`=0 is ignored. No queuing.
- In RESP, `rsp_valid`=1 and `rsp_data` is stable until `rsp_valid && rsp_ready`; the next cycle is IDLE.
- Reset values: `sioc`=1, `siod_o`=1, `siod_oe`=1, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `busy`=0, FSM=IDLE.
  - Reset mid-transaction forces these values immediately. The truncated bus cycle is abandoned; the camera resynchronises on the next START.

## Timing
- `cmd_ready` falls the cycle after accept. Bus activity (START q0) begins that same cycle.
- Write: 4+108+4 = 116 quarters = 116·`CLK_DIV` clks from accept until `cmd_ready`=1 again.
- Read: 164 quarters, then RESP. `rsp_valid` rises in the first cycle after STOP q3 ends.
- Back-to-back writes: a new accept can occur in the first IDLE cycle.
- `busy` = !(state==IDLE).
- Outputs are registered with no combinational path from inputs. The only exception is `cmd_ready`, which is registered from state.
- The prescaler counter is $clog2(`CLK_DIV`) bits wide and wraps at `CLK_DIV`-1.

## Structure
- `sccb_pkg` holds:
  - the state enum;
  - quarter C/D constants for START, STOP and GAP;
  - `OV7670_ID` = 7'h21.
- Sub-module `sccb_quarter_tick` (counter + `qtick`, with clear-in-IDLE) is instantiated once.

## Test plan
- Write test, `CLK_DIV`=4: cmd {dev 21, reg 12, data 80, write}.
  - Bus monitor decodes START, 42, 12, 80, STOP.
  - `cmd_ready` is low for exactly 464 clks.
- Read test: cmd {21, 0A, read}, slave model drives 76.
  - Monitor decodes START 42 0A STOP, then START 43 <76> NA STOP.
  - `rsp_data`=76.
  - `siod_oe`=0 during the 8 read bits.
- Response backpressure: `rsp_ready`=0 for 50 clks after the read.
  - `rsp_valid`/`rsp_data` are held for all 50 clks.
  - A `cmd_valid` pulse during that time is not accepted.
- Reset test: assert `reset_` during the second byte of a write.
  - Outputs are 1/1/1 with `cmd_ready`=1 the same cycle.
  - A following write decodes correctly.
- Busy test: hold `cmd_valid` high throughout a write with changing `cmd_wdata`. The bus carries only the value registered at accept.
- Back-to-back test: two writes in a row, with `cmd_ready`=1 for exactly 1 cycle between them. The START of the second write follows a complete STOP.
